// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light controller and its interval timer.
// Holds timer FSM encodings, default tick counts and a config sanity check.
package traffic_pkg;

    localparam logic [1:0] TMR_IDLE = 2'd0;
    localparam logic [1:0] TMR_RUN  = 2'd1;
    localparam logic [1:0] TMR_DONE = 2'd2;

    localparam int TS_TICKS_DEF = 3;
    localparam int TL_TICKS_DEF = 8;

    function automatic bit timer_cfg_ok(input int cw, input int ts,
                                        input int tl, input int ps);
        return (ts >= 1) && (ts < tl) && (tl <= (1 << cw) - 1) && (ps >= 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into ticks: one tick every PRESCALE enabled cycles.
// clr restarts the division and suppresses the tick on that edge.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == PW'(PRESCALE - 1));
    assign tick   = en && !clr && w_wrap;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/traffic_interval_timer.sv
// Measures time since the last start pulse and raises sticky short/long flags.
// Elapsed saturates at TL_TICKS; a start pulse always wins over a tick.
module traffic_interval_timer
    import traffic_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int TS_TICKS = TS_TICKS_DEF,
    parameter int TL_TICKS = TL_TICKS_DEF,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st,
    output logic             ts,
    output logic             tl,
    output logic             busy,
    output logic [CNT_W-1:0] elapsed
);

    if (!timer_cfg_ok(CNT_W, TS_TICKS, TL_TICKS, PRESCALE)) begin : g_bad_cfg
        $error("traffic_interval_timer: illegal tick/width parameters");
    end

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_elapsed;
    logic             r_ts;
    logic             r_tl;
    logic             r_busy;
    logic             w_tick;
    logic             w_run;
    logic [CNT_W-1:0] w_next;

    assign w_run  = (r_state == TMR_RUN);
    assign w_next = r_elapsed + CNT_W'(1);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (st),
        .en    (w_run),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= TMR_IDLE;
            r_elapsed <= '0;
            r_ts      <= 1'b0;
            r_tl      <= 1'b0;
            r_busy    <= 1'b0;
        end else if (st) begin
            r_state   <= TMR_RUN;
            r_elapsed <= '0;
            r_ts      <= 1'b0;
            r_tl      <= 1'b0;
            r_busy    <= 1'b1;
        end else if (w_run && w_tick) begin
            r_elapsed <= w_next;
            if (w_next == CNT_W'(TS_TICKS)) begin
                r_ts <= 1'b1;
            end
            // Reaching the long threshold also freezes elapsed in DONE
            if (w_next == CNT_W'(TL_TICKS)) begin
                r_tl    <= 1'b1;
                r_state <= TMR_DONE;
                r_busy  <= 1'b0;
            end
        end
    end

    assign ts      = r_ts;
    assign tl      = r_tl;
    assign busy    = r_busy;
    assign elapsed = r_elapsed;

endmodule
